// File: rtl/restoring_divider_seq.sv
// Multi-cycle unsigned restoring divider: one subtract-and-shift step per clock
// around a WIDTH+1-bit ripple subtractor, with valid/ready request and valid/ack result.
module restoring_divider_seq #(
  parameter int WIDTH = 4
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_ready,
  output logic             out_valid,
  input  logic             in_ack,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic             out_div0
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] qreg_q, qreg_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] res_q_q, res_q_d;
  logic [WIDTH-1:0] res_r_q, res_r_d;
  logic             div0_q, div0_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             new_bit;

  // Ripple subtract: shifted + ~{0,divisor} + 1, carry threaded bit by bit.
  always_comb begin
    logic [WIDTH:0] b_inv;
    logic           carry;
    shifted = {rem_q, qreg_q[WIDTH-1]};
    b_inv   = ~{1'b0, dvs_q};
    carry   = 1'b1;
    trial   = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      trial[i] = shifted[i] ^ b_inv[i] ^ carry;
      carry    = (shifted[i] & b_inv[i]) | (carry & (shifted[i] ^ b_inv[i]));
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    qreg_d  = qreg_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    res_q_d = res_q_q;
    res_r_d = res_r_q;
    div0_d  = div0_q;
    new_bit = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_y == '0) begin
            res_q_d = '1;
            res_r_d = in_x;
            div0_d  = 1'b1;
            state_d = DONE;
          end else begin
            qreg_d  = in_x;
            dvs_d   = in_y;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        new_bit = ~trial[WIDTH];
        rem_d   = new_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        qreg_d  = {qreg_q[WIDTH-2:0], new_bit};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          res_q_d = qreg_d;
          res_r_d = rem_d;
          div0_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (in_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      qreg_q  <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      res_q_q <= '0;
      res_r_q <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qreg_q  <= qreg_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      res_q_q <= res_q_d;
      res_r_q <= res_r_d;
      div0_q  <= div0_d;
    end
  end

  assign out_ready = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_q     = res_q_q;
  assign out_r     = res_r_q;
  assign out_div0  = div0_q;

endmodule
